// File: rtl/mem_access_ctrl_pkg.sv
// LC-3b shared types for the memory stage: opcodes, MEM FSM states, captured-request payload.
package lc3b_types;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned BE_W   = 2;

    typedef logic [WORD_W-1:0] lc3b_word;

    typedef enum logic [3:0] {
        OP_BR  = 4'b0000, OP_ADD = 4'b0001, OP_LDB = 4'b0010, OP_STB  = 4'b0011,
        OP_JSR = 4'b0100, OP_AND = 4'b0101, OP_LDR = 4'b0110, OP_STR  = 4'b0111,
        OP_RTI = 4'b1000, OP_NOT = 4'b1001, OP_LDI = 4'b1010, OP_STI  = 4'b1011,
        OP_JMP = 4'b1100, OP_SHF = 4'b1101, OP_LEA = 4'b1110, OP_TRAP = 4'b1111
    } lc3b_opcode;

    typedef enum logic [1:0] {IDLE, ACCESS, INDIR} mem_state_t;

    typedef struct packed {
        lc3b_opcode op;
        lc3b_word   addr;
        lc3b_word   wdata;
    } mem_req_t;

    function automatic logic is_mem_op(lc3b_opcode op);
        return (op == OP_LDR) || (op == OP_LDB) || (op == OP_STR) ||
               (op == OP_STB) || (op == OP_LDI) || (op == OP_STI);
    endfunction

    function automatic logic is_indirect(lc3b_opcode op);
        return (op == OP_LDI) || (op == OP_STI);
    endfunction

    function automatic logic is_direct_store(lc3b_opcode op);
        return (op == OP_STR) || (op == OP_STB);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_align.sv
// Byte-lane helper: LDB byte extract with sign extension, STB data replication and lane enables.
module mem_byte_align
    import lc3b_types::*;
(
    input  logic            addr_lsb,
    input  lc3b_word        rdata,
    input  lc3b_word        wdata,
    output lc3b_word        ldb_data,
    output lc3b_word        stb_wdata,
    output logic [BE_W-1:0] stb_be
);

    logic [7:0] rbyte;

    always_comb begin
        rbyte     = addr_lsb ? rdata[15:8] : rdata[7:0];
        ldb_data  = {{8{rbyte[7]}}, rbyte};
        stb_wdata = {wdata[7:0], wdata[7:0]};
        stb_be    = addr_lsb ? 2'b10 : 2'b01;
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// LC-3b memory stage: captures one instruction from EX and sequences its dcache access(es).
// Optional stall-cycle counter enabled by defining MEM_PERF_CNT_EN.
module mem_access_ctrl
    import lc3b_types::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_mem,
    input  logic              valid_in,
    input  logic [3:0]        op_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic              dmem_resp,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [ADDR_W-1:0] dmem_address,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [1:0]        dmem_byte_enable,
    output logic              mem_stall,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic [31:0]       perf_stall_cycles
);

    mem_state_t state_q, state_d;
    mem_req_t   req_q, req_d;
    lc3b_word   ptr_q, ptr_d;
    logic       wb_valid_d;
    lc3b_word   wb_data_d;
    lc3b_opcode op_new;
    lc3b_word   ldb_data, stb_wdata;
    logic [1:0] stb_be;
    logic       final_acc_c, resp_final_c, capture_ok_c, capture_legal_c;

    assign op_new = lc3b_opcode'(op_in);

    mem_byte_align u_align (
        .addr_lsb  (req_q.addr[0]),
        .rdata     (dmem_rdata),
        .wdata     (req_q.wdata),
        .ldb_data  (ldb_data),
        .stb_wdata (stb_wdata),
        .stb_be    (stb_be)
    );

    // A new capture is accepted while idle or alongside the last response of the current op.
    always_comb begin
        final_acc_c     = (state_q == INDIR) || ((state_q == ACCESS) && !is_indirect(req_q.op));
        resp_final_c    = dmem_resp && final_acc_c;
        mem_stall       = (state_q != IDLE) && !resp_final_c;
        capture_ok_c    = (state_q == IDLE) || resp_final_c;
        // a non-mem op next to a final response would need a second wb slot, so it is illegal
        capture_legal_c = (state_q == IDLE) ||
                          (resp_final_c && (!valid_in || is_mem_op(op_new)));
    end

    // Request decode from registered state and captured instruction.
    always_comb begin
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_address     = '0;
        dmem_wdata       = req_q.wdata;
        dmem_byte_enable = 2'b11;
        case (state_q)
            ACCESS: begin
                dmem_write   = is_direct_store(req_q.op);
                dmem_read    = !is_direct_store(req_q.op);
                dmem_address = ((req_q.op == OP_LDB) || (req_q.op == OP_STB)) ?
                               req_q.addr : {req_q.addr[15:1], 1'b0};
                if (req_q.op == OP_STB) begin
                    dmem_wdata       = stb_wdata;
                    dmem_byte_enable = stb_be;
                end
            end
            INDIR: begin
                dmem_read    = (req_q.op == OP_LDI);
                dmem_write   = (req_q.op == OP_STI);
                dmem_address = {ptr_q[15:1], 1'b0};
            end
            default: ;
        endcase
    end

    // Next-state, capture and writeback result.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        ptr_d      = ptr_q;
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data;
        case (state_q)
            ACCESS: begin
                if (dmem_resp) begin
                    if (is_indirect(req_q.op)) begin
                        ptr_d   = dmem_rdata;
                        state_d = INDIR;
                    end else begin
                        state_d    = IDLE;
                        wb_valid_d = 1'b1;
                        case (req_q.op)
                            OP_LDR:  wb_data_d = dmem_rdata;
                            OP_LDB:  wb_data_d = ldb_data;
                            default: wb_data_d = req_q.addr;
                        endcase
                    end
                end
            end
            INDIR: begin
                if (dmem_resp) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_data_d  = (req_q.op == OP_LDI) ? dmem_rdata : ptr_q;
                end
            end
            default: ;
        endcase
        if (load_mem && valid_in && capture_ok_c) begin
            if (is_mem_op(op_new)) begin
                req_d   = '{op: op_new, addr: addr_in, wdata: wdata_in};
                state_d = ACCESS;
            end else if (state_q == IDLE) begin
                wb_valid_d = 1'b1;
                wb_data_d  = addr_in;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            req_q    <= '0;
            ptr_q    <= '0;
            wb_valid <= 1'b0;
            wb_data  <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            ptr_q    <= ptr_d;
            wb_valid <= wb_valid_d;
            wb_data  <= wb_data_d;
        end
    end

`ifdef MEM_PERF_CNT_EN
    logic [31:0] perf_q;

    // Saturating count of cycles EX is held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_q <= '0;
        end else if (mem_stall && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall_cycles = perf_q;
`else
    assign perf_stall_cycles = 32'd0;
`endif

`ifndef SYNTHESIS
    load_mem_protocol: assert property (@(posedge clk) disable iff (!reset_n)
                                        load_mem |-> capture_legal_c)
        else $error("mem_access_ctrl: load_mem while MEM busy");
`endif

endmodule
